// File: rtl/regfile_dump.sv
//----------------------------------------------------------------------------
// regfile_dump
//   Sequential reader for the 32 x 32-bit register file. A start pulse walks
//   the shared read port from FIRST_REG to LAST_REG and streams each word out
//   as an (address, data) beat on a valid/ready interface.
//
//   Optional feature: define REGDUMP_CHECKSUM_EN to append a checksum beat
//   (out_addr=0, out_data=XOR of all dumped words, out_last=1).
//
// Parameters
//   FIRST_REG    first register index dumped (0..31)
//   LAST_REG     last register index dumped (FIRST_REG..31)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   start        dump request, sampled only while idle
//   busy         high from the cycle after start is accepted until done
//   done         one-cycle pulse after the final beat handshakes
//   rf_read_reg  register file read address (0 while idle)
//   rf_read_data register file read data (combinational, same cycle)
//   out_valid    beat valid
//   out_ready    downstream accept
//   out_addr     register index of the current beat
//   out_data     register contents of the current beat
//   out_last     final beat of the dump
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_read_reg,
  input  logic [31:0] rf_read_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        out_last
);

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t     r_state;
  logic [4:0] r_ptr;
`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] r_csum;
`endif

  logic w_hs;
  logic w_at_last;

  assign w_hs      = out_valid & out_ready;
  assign w_at_last = (r_ptr == LAST_A);

  // rf_read_reg is kept as its own register that tracks r_ptr outside IDLE,
  // so the read address is glitch-free and still 0 while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= FIRST_A;
      busy        <= 1'b0;
      done        <= 1'b0;
      rf_read_reg <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_last    <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr       <= FIRST_A;
            rf_read_reg <= FIRST_A;
            busy        <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
            r_csum      <= '0;
`endif
            r_state     <= S_READ;
          end
        end

        S_READ: begin
          out_data  <= rf_read_data;
          out_addr  <= r_ptr;
`ifdef REGDUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          r_csum    <= r_csum ^ rf_read_data;
`else
          out_last  <= w_at_last;
`endif
          out_valid <= 1'b1;
          r_state   <= S_HOLD;
        end

        S_HOLD: begin
          if (w_hs) begin
            if (!w_at_last) begin
              r_ptr       <= r_ptr + 5'd1;
              rf_read_reg <= r_ptr + 5'd1;
              out_valid   <= 1'b0;
              r_state     <= S_READ;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // Checksum beat is loaded straight from HOLD; out_valid stays high.
              out_addr  <= '0;
              out_data  <= r_csum;
              out_last  <= 1'b1;
              r_state   <= S_CSUM;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_DONE;
`endif
            end
          end
        end

`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM: begin
          if (w_hs) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            r_state   <= S_DONE;
          end
        end
`endif

        S_DONE: begin
          done        <= 1'b0;
          busy        <= 1'b0;
          rf_read_reg <= '0;
          r_state     <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
